// File: rtl/mem_stage_lsu_pkg.sv
// Shared funct3 codes and FSM state encoding for the mem_stage_lsu load/store unit.
package mem_stage_lsu_pkg;
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LD  = 3'd3;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_LWU = 3'd6;

   typedef enum logic {LSU_IDLE = 1'b0, LSU_WAIT = 1'b1} lsu_state_e;
endpackage

// File: rtl/mem_stage_lsu_dmem.sv
// Byte-enable data memory, DEPTH x DWIDTH, asynchronous array read followed by a
// MEM_LAT-1 deep read pipe; the LSU output register forms the last latency stage.
module mem_stage_lsu_dmem #(
   parameter int DWIDTH  = 32,
   parameter int DEPTH   = 36,
   parameter int MEM_LAT = 1,
   parameter int IW      = 30
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [DWIDTH/8-1:0] i_be,
   input  logic [IW-1:0]       i_idx,
   input  logic [DWIDTH-1:0]   i_wdata,
   input  logic                i_adv,
   output logic [DWIDTH-1:0]   o_rdata
);
   localparam int NB = DWIDTH / 8;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic              w_inrange;
   logic [AW-1:0]     w_a;
   logic [DWIDTH-1:0] w_rd;

   // Out-of-range indices never touch the array, so no aliasing through w_a truncation.
   assign w_inrange = (i_idx < IW'(DEPTH));
   assign w_a       = i_idx[AW-1:0];
   assign w_rd      = w_inrange ? r_mem[w_a] : '0;

   always_ff @(posedge clk) begin
      if (i_we && w_inrange) begin
         for (int b = 0; b < NB; b++) begin
            if (i_be[b]) r_mem[w_a][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
      end
   end

   generate
      if (MEM_LAT == 1) begin : g_nopipe
         logic w_unused_adv;
         assign w_unused_adv = i_adv;
         assign o_rdata      = w_rd;
      end else begin : g_pipe
         logic [DWIDTH-1:0] r_pipe [MEM_LAT-1];
         always_ff @(posedge clk) begin
            if (i_adv) begin
               r_pipe[0] <= w_rd;
               for (int i = 1; i < MEM_LAT - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
         end
         assign o_rdata = r_pipe[MEM_LAT-2];
      end
   endgenerate
endmodule

// File: rtl/mem_stage_lsu.sv
// RV32/RV64 memory stage: FSM, load extension and writeback registers around mem_stage_lsu_dmem.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses retire without effect, flagged on lsu_o_misalign).
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 5,
   parameter int FUNCT_WIDTH = 3,
   parameter int DEPTH       = 36,
   parameter int MEM_LAT     = 1
) (
   input  logic                   lsu_clk,
   input  logic                   lsu_rst,
   input  logic                   lsu_i_ce,
   input  logic                   lsu_i_stall,
   input  logic                   lsu_i_flush,
   input  logic                   lsu_i_load,
   input  logic                   lsu_i_store,
   input  logic [FUNCT_WIDTH-1:0] lsu_i_funct3,
   input  logic [DWIDTH-1:0]      lsu_i_addr,
   input  logic [DWIDTH-1:0]      lsu_i_wdata,
   input  logic                   lsu_i_rd_we,
   input  logic [AWIDTH-1:0]      lsu_i_rd_addr,
   input  logic [DWIDTH-1:0]      lsu_i_rd_data,
   output logic                   lsu_o_ce,
   output logic                   lsu_o_stall,
   output logic                   lsu_o_flush,
   output logic                   lsu_o_rd_we,
   output logic [AWIDTH-1:0]      lsu_o_rd_addr,
   output logic [DWIDTH-1:0]      lsu_o_rd_data,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic                   lsu_o_misalign,
`endif
   output logic [DWIDTH-1:0]      lsu_o_load_data
);
   localparam int NB = DWIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int IW = DWIDTH - OW;

   lsu_state_e        r_state;
   logic [3:0]        r_cnt;
   logic [OW-1:0]     r_off;
   logic [2:0]        r_f3;
   logic              r_rd_we;
   logic [AWIDTH-1:0] r_rd_addr;

   logic [2:0]        w_f3;
   logic [1:0]        w_szl;
   logic [OW-1:0]     w_mask, w_off;
   logic [NB-1:0]     w_be;
   logic              w_accept, w_do_access, w_wait_go;
   logic [DWIDTH-1:0] w_wdata, w_rdata, w_ext_now, w_ext_wait;

   function automatic logic [DWIDTH-1:0] f_extend(input logic [DWIDTH-1:0] i_word,
                                                   input logic [OW-1:0]     i_off,
                                                   input logic [2:0]        i_f3);
      logic [DWIDTH-1:0] v_sh, v_res;
      int                v_nbits;
      logic              v_fill;
      v_sh    = i_word >> {i_off, 3'b000};
      v_nbits = DWIDTH;
      v_fill  = 1'b0;
      case (i_f3)
         F3_LB:   begin v_nbits = 8;  v_fill = v_sh[7];  end
         F3_LH:   begin v_nbits = 16; v_fill = v_sh[15]; end
         F3_LW:   begin v_nbits = 32; v_fill = v_sh[31]; end
         F3_LBU:  v_nbits = 8;
         F3_LHU:  v_nbits = 16;
         F3_LWU:  v_nbits = 32;
         F3_LD:   v_nbits = DWIDTH;
         default: v_nbits = DWIDTH;
      endcase
      for (int b = 0; b < DWIDTH; b++) v_res[b] = (b < v_nbits) ? v_sh[b] : v_fill;
      return v_res;
   endfunction

   assign w_f3 = lsu_i_funct3[2:0];

   always_comb begin
      w_szl = w_f3[1:0];
      if (DWIDTH == 32 && w_f3[1:0] == 2'd3) w_szl = 2'd2;
   end

   assign w_mask = OW'((1 << w_szl) - 1);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_do_access = ~|(lsu_i_addr[OW-1:0] & w_mask);
   assign w_off       = lsu_i_addr[OW-1:0];
`else
   assign w_do_access = 1'b1;
   assign w_off       = lsu_i_addr[OW-1:0] & ~w_mask;
`endif

   always_comb begin
      w_be = '0;
      for (int b = 0; b < NB; b++)
         w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << w_szl));
   end

   assign lsu_o_stall = lsu_i_stall | (r_state == LSU_WAIT);
   assign w_accept    = lsu_i_ce & ~lsu_i_flush & ~lsu_o_stall;
   assign w_wait_go   = lsu_i_load & w_do_access & (MEM_LAT > 1);
   assign w_wdata     = lsu_i_wdata << {w_off, 3'b000};

   mem_stage_lsu_dmem #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .MEM_LAT(MEM_LAT),
      .IW     (IW)
   ) u_dmem (
      .clk    (lsu_clk),
      .i_we   (w_accept & lsu_i_store & w_do_access),
      .i_be   (w_be),
      .i_idx  (lsu_i_addr[DWIDTH-1:OW]),
      .i_wdata(w_wdata),
      .i_adv  (~lsu_i_stall),
      .o_rdata(w_rdata)
   );

   assign w_ext_now  = f_extend(w_rdata, w_off, w_f3);
   assign w_ext_wait = f_extend(w_rdata, r_off, r_f3);

   // Request fields held for the load completing after the wait states.
   always_ff @(posedge lsu_clk) begin
      if (w_accept) begin
         r_off     <= w_off;
         r_f3      <= w_f3;
         r_rd_we   <= lsu_i_rd_we;
         r_rd_addr <= lsu_i_rd_addr;
      end
   end

   always_ff @(posedge lsu_clk or negedge lsu_rst) begin
      if (!lsu_rst) begin
         r_state         <= LSU_IDLE;
         r_cnt           <= '0;
         lsu_o_ce        <= 1'b0;
         lsu_o_flush     <= 1'b0;
         lsu_o_rd_we     <= 1'b0;
         lsu_o_rd_addr   <= '0;
         lsu_o_rd_data   <= '0;
         lsu_o_load_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         lsu_o_misalign  <= 1'b0;
`endif
      end else begin
         lsu_o_flush <= lsu_i_flush;
         if (lsu_i_flush) begin
            r_state     <= LSU_IDLE;
            r_cnt       <= '0;
            lsu_o_ce    <= 1'b0;
            lsu_o_rd_we <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_o_misalign <= 1'b0;
`endif
         end else if (!lsu_i_stall) begin
            if (r_state == LSU_WAIT) begin
               if (r_cnt == 4'd1) begin
                  r_state         <= LSU_IDLE;
                  r_cnt           <= '0;
                  lsu_o_ce        <= 1'b1;
                  lsu_o_rd_we     <= r_rd_we;
                  lsu_o_rd_addr   <= r_rd_addr;
                  lsu_o_rd_data   <= w_ext_wait;
                  lsu_o_load_data <= w_ext_wait;
               end else begin
                  r_cnt       <= r_cnt - 4'd1;
                  lsu_o_ce    <= 1'b0;
                  lsu_o_rd_we <= 1'b0;
               end
            end else if (lsu_i_ce) begin
               if (w_wait_go) begin
                  r_state     <= LSU_WAIT;
                  r_cnt       <= 4'(MEM_LAT - 1);
                  lsu_o_ce    <= 1'b0;
                  lsu_o_rd_we <= 1'b0;
               end else begin
                  lsu_o_ce        <= 1'b1;
                  lsu_o_rd_we     <= lsu_i_rd_we & w_do_access;
                  lsu_o_rd_addr   <= lsu_i_rd_addr;
                  lsu_o_rd_data   <= (lsu_i_load & w_do_access) ? w_ext_now : lsu_i_rd_data;
                  lsu_o_load_data <= (lsu_i_load & w_do_access) ? w_ext_now : '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  lsu_o_misalign  <= ~w_do_access;
`endif
               end
            end else begin
               lsu_o_ce    <= 1'b0;
               lsu_o_rd_we <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
               lsu_o_misalign <= 1'b0;
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (DWIDTH=32, DEPTH=36, MEM_LAT=3); trap-mode vectors run when LSU_MISALIGN_TRAP_EN is defined.
module tb_mem_stage_lsu;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_ce, i_stall, i_flush, i_load, i_store, i_rd_we;
   logic [2:0]  i_f3;
   logic [31:0] i_addr, i_wdata, i_rd_data;
   logic [4:0]  i_rd_addr;
   logic        o_ce, o_stall, o_flush, o_rd_we;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data, o_load_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        o_misalign;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(
      .DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .DEPTH(36), .MEM_LAT(3)
   ) u_dut (
      .lsu_clk        (clk),
      .lsu_rst        (rst_n),
      .lsu_i_ce       (i_ce),
      .lsu_i_stall    (i_stall),
      .lsu_i_flush    (i_flush),
      .lsu_i_load     (i_load),
      .lsu_i_store    (i_store),
      .lsu_i_funct3   (i_f3),
      .lsu_i_addr     (i_addr),
      .lsu_i_wdata    (i_wdata),
      .lsu_i_rd_we    (i_rd_we),
      .lsu_i_rd_addr  (i_rd_addr),
      .lsu_i_rd_data  (i_rd_data),
      .lsu_o_ce       (o_ce),
      .lsu_o_stall    (o_stall),
      .lsu_o_flush    (o_flush),
      .lsu_o_rd_we    (o_rd_we),
      .lsu_o_rd_addr  (o_rd_addr),
      .lsu_o_rd_data  (o_rd_data),
`ifdef LSU_MISALIGN_TRAP_EN
      .lsu_o_misalign (o_misalign),
`endif
      .lsu_o_load_data(o_load_data)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [4:0] rda, input logic [31:0] rdd);
      i_ce = 1'b1; i_load = ld; i_store = st; i_f3 = f3; i_addr = addr;
      i_wdata = wdata; i_rd_we = we; i_rd_addr = rda; i_rd_data = rdd;
      tick();
      i_ce = 1'b0; i_load = 1'b0; i_store = 1'b0;
   endtask

   task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data);
      issue(1'b0, 1'b1, f3, addr, data, 1'b0, 5'd0, 32'h0);
      chk({tag, "_ce"}, {31'b0, o_ce}, 32'd1);
   endtask

   // Load with MEM_LAT=3: stalled after accept, result two edges later.
   task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
      issue(1'b1, 1'b0, f3, addr, 32'h0, 1'b1, 5'd7, 32'h0000_0BAD);
      chk({tag, "_stall"}, {31'b0, o_stall}, 32'd1);
      tick();
      tick();
      chk({tag, "_ce"}, {31'b0, o_ce}, 32'd1);
      chk({tag, "_data"}, o_rd_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; i_ce = 0; i_stall = 0; i_flush = 0; i_load = 0; i_store = 0;
      i_rd_we = 0; i_f3 = 3'd0; i_addr = 0; i_wdata = 0; i_rd_addr = 0; i_rd_data = 0;
      tick();
      tick();
      chk("rst_ce", {31'b0, o_ce}, 32'd0);
      chk("rst_stall", {31'b0, o_stall}, 32'd0);
      chk("rst_we", {31'b0, o_rd_we}, 32'd0);
      chk("rst_flush", {31'b0, o_flush}, 32'd0);
      chk("rst_data", o_rd_data, 32'd0);
      chk("rst_ldata", o_load_data, 32'd0);
      rst_n = 1'b1;
      tick();

      // Store then load the same word back to back
      store("sw8", 3'd2, 32'd8, 32'hDEAD_BEEF);
      chk("sw8_we", {31'b0, o_rd_we}, 32'd0);
      issue(1'b1, 1'b0, 3'd2, 32'd8, 32'h0, 1'b1, 5'd5, 32'h0000_1234);
      chk("lw8_ce0", {31'b0, o_ce}, 32'd0);
      chk("lw8_stall0", {31'b0, o_stall}, 32'd1);
      tick();
      chk("lw8_ce1", {31'b0, o_ce}, 32'd0);
      chk("lw8_stall1", {31'b0, o_stall}, 32'd1);
      tick();
      chk("lw8_ce2", {31'b0, o_ce}, 32'd1);
      chk("lw8_stall2", {31'b0, o_stall}, 32'd0);
      chk("lw8_data", o_rd_data, 32'hDEAD_BEEF);
      chk("lw8_ldata", o_load_data, 32'hDEAD_BEEF);
      chk("lw8_we", {31'b0, o_rd_we}, 32'd1);
      chk("lw8_rda", {27'b0, o_rd_addr}, 32'd5);
      tick();
      chk("lw8_ce3", {31'b0, o_ce}, 32'd0);

      // Byte store and sign/zero extension
      store("sb9", 3'd0, 32'd9, 32'h1234_5680);
      load_chk("lb9", 3'd0, 32'd9, 32'hFFFF_FF80);
      load_chk("lbu9", 3'd4, 32'd9, 32'h0000_0080);
      load_chk("lw8b", 3'd2, 32'd8, 32'hDEAD_80EF);
      load_chk("lh10", 3'd1, 32'd10, 32'hFFFF_DEAD);
      load_chk("lhu10", 3'd5, 32'd10, 32'h0000_DEAD);
`ifndef LSU_MISALIGN_TRAP_EN
      load_chk("lw11", 3'd2, 32'd11, 32'hDEAD_80EF);
`endif
      store("sw12", 3'd2, 32'd12, 32'h1122_3344);
      load_chk("lw12", 3'd2, 32'd12, 32'h1122_3344);

      // Flush during WAIT aborts the load
      issue(1'b1, 1'b0, 3'd2, 32'd8, 32'h0, 1'b1, 5'd9, 32'h0);
      chk("fl_stall0", {31'b0, o_stall}, 32'd1);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("fl_ce", {31'b0, o_ce}, 32'd0);
      chk("fl_we", {31'b0, o_rd_we}, 32'd0);
      chk("fl_oflush", {31'b0, o_flush}, 32'd1);
      chk("fl_idle", {31'b0, o_stall}, 32'd0);
      tick();
      chk("fl_oflush_off", {31'b0, o_flush}, 32'd0);
      chk("fl_ce_late", {31'b0, o_ce}, 32'd0);
      tick();
      chk("fl_ce_late2", {31'b0, o_ce}, 32'd0);

      // Flushed store must not write
      store("sw16", 3'd2, 32'd16, 32'h0000_0055);
      i_flush = 1'b1;
      issue(1'b0, 1'b1, 3'd2, 32'd16, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0);
      i_flush = 1'b0;
      chk("flst_ce", {31'b0, o_ce}, 32'd0);
      load_chk("lw16", 3'd2, 32'd16, 32'h0000_0055);

      // Downstream stall freezes the wait counter
      issue(1'b1, 1'b0, 3'd2, 32'd12, 32'h0, 1'b1, 5'd3, 32'h0);
      i_stall = 1'b1;
      tick();
      tick();
      chk("stl_ce", {31'b0, o_ce}, 32'd0);
      i_stall = 1'b0;
      tick();
      chk("stl_ce1", {31'b0, o_ce}, 32'd0);
      chk("stl_stall1", {31'b0, o_stall}, 32'd1);
      tick();
      chk("stl_ce2", {31'b0, o_ce}, 32'd1);
      chk("stl_data", o_rd_data, 32'h1122_3344);

      // Out-of-range index: loads return 0, stores dropped (no aliasing)
      store("sw0", 3'd2, 32'd0, 32'h0A0B_0C0D);
      store("sw140", 3'd2, 32'd140, 32'h7777_8888);
      store("sw144", 3'd2, 32'd144, 32'hFFFF_FFFF);
      store("sw256", 3'd2, 32'd256, 32'hFFFF_FFFF);
      load_chk("lw144", 3'd2, 32'd144, 32'h0);
      load_chk("lw0", 3'd2, 32'd0, 32'h0A0B_0C0D);
      load_chk("lw140", 3'd2, 32'd140, 32'h7777_8888);

`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b1, 1'b0, 3'd2, 32'd6, 32'h0, 1'b1, 5'd4, 32'h0);
      chk("mis_ce", {31'b0, o_ce}, 32'd1);
      chk("mis_flag", {31'b0, o_misalign}, 32'd1);
      chk("mis_we", {31'b0, o_rd_we}, 32'd0);
      issue(1'b0, 1'b1, 3'd2, 32'd10, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
      chk("mis_st_flag", {31'b0, o_misalign}, 32'd1);
      tick();
      chk("mis_flag_off", {31'b0, o_misalign}, 32'd0);
      load_chk("mis_lw8", 3'd2, 32'd8, 32'hDEAD_80EF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
